// File: rtl/line_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_pkg
// Purpose  : Shared types and raster limits for the line-draw scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package line_pkg;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int CMD_W = 2*XW + 2*YW;

    localparam logic [XW-1:0] H_ACTIVE = 11'd800;
    localparam logic [YW-1:0] V_ACTIVE = 10'd480;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
    } line_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        LAUNCH    = 2'd2,
        RUN       = 2'd3
    } sched_state_t;

    function automatic logic cmd_in_raster(input line_cmd_t c);
        return (c.x0 < H_ACTIVE) && (c.x1 < H_ACTIVE) &&
               (c.y0 < V_ACTIVE) && (c.y1 < V_ACTIVE);
    endfunction
endpackage
`default_nettype wire

// File: rtl/line_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : line_cmd_fifo
// Purpose  : Circular command FIFO for line commands; full blocks push.
// Revision : 1.0 - initial release
// ============================================================================
module line_cmd_fifo
    import line_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  line_cmd_t              push_data,
    input  logic                   pop,
    output line_cmd_t              pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    line_cmd_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/line_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : line_draw_scheduler
// Purpose  : Round-robin arbiter + command FIFO feeding one frame-aligned
//            Bresenham engine. Optional LINE_CLIP_EN drops off-raster commands.
// Revision : 1.0 - initial release
// ============================================================================
module line_draw_scheduler
    import line_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*42-1:0]          req_cmd,
    output logic [NREQ-1:0]             gnt,
    input  logic                        frame_sync,
    output logic                        eng_start,
    output logic [10:0]                 eng_x0,
    output logic [9:0]                  eng_y0,
    output logic [10:0]                 eng_x1,
    output logic [9:0]                  eng_y1,
    input  logic                        eng_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_timeout
`ifdef LINE_CLIP_EN
    ,
    output logic                        drop_seen
`endif
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    sched_state_t  state_q, state_d;
    line_cmd_t     cmd_q, cmd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          eng_start_q, eng_start_d;
    logic          err_q, err_d;
    logic [PW-1:0] gnt_idx;
    logic          gnt_vld;
    line_cmd_t     gnt_cmd, head_cmd;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    int            idx;

    // Grant is suppressed during reset so nothing is accepted into a flushing FIFO.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_cmd = '0;
        idx     = 0;
        if (!reset && !fifo_full) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!gnt_vld && req[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(idx);
                    gnt_cmd = line_cmd_t'(req_cmd[idx*CMD_W +: CMD_W]);
                end
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

`ifdef LINE_CLIP_EN
    logic drop_q, drop_d;
    assign fifo_push = gnt_vld && cmd_in_raster(gnt_cmd);
    assign drop_d    = drop_q || (gnt_vld && !cmd_in_raster(gnt_cmd));
    assign drop_seen = drop_q;
`else
    assign fifo_push = gnt_vld;
`endif

    line_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (gnt_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        timer_d  = timer_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = head_cmd;
                    state_d  = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (frame_sync) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = RUN;
                timer_d = '0;
            end
            RUN: begin
                if (eng_done) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYC-1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        eng_start_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            timer_q     <= '0;
            rr_ptr_q    <= '0;
            eng_start_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef LINE_CLIP_EN
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            timer_q     <= timer_d;
            rr_ptr_q    <= rr_ptr_d;
            eng_start_q <= eng_start_d;
            err_q       <= err_d;
`ifdef LINE_CLIP_EN
            drop_q      <= drop_d;
`endif
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_x0      = cmd_q.x0;
    assign eng_y0      = cmd_q.y0;
    assign eng_x1      = cmd_q.x1;
    assign eng_y1      = cmd_q.y1;
    assign err_timeout = err_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;
endmodule
`default_nettype wire
